lut_table_loader: RTL and testbench
===================================

Name: lut_table_loader

Overview:
- Runtime-programmable LogicNets neuron for the write side of the neuron truth table. Fixed neurons hold a hard-coded table that is only ever read; this block owns the writer.
- A config stream fills a shadow table, and a validated commit swaps it into the active table. The active table serves registered neuron lookups.
- Sits between the layer-config loader and one neuron slot, so retrained tables can be deployed without resynthesis.

Parameters:
- IN_BITS, 6, neuron input width; table depth is 2^IN_BITS entries.
- OUT_BITS, 1, neuron output width per entry.
- WORD_W, 8, config beat width in bits; (2^IN_BITS * OUT_BITS) must be a multiple of WORD_W.
- Derived, not overridable: NBEATS = (2^IN_BITS * OUT_BITS) / WORD_W. Default is 8.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat accepted when cfg_valid & cfg_ready.
- cfg_data  in  WORD_W  table bits, entry-major, LSB first.
- cfg_last  in  1  marks the final beat of a table.
- cfg_done  out  1  one-cycle pulse when a commit takes effect.
- cfg_err  out  1  sticky framing-error flag.
- err_clr  in  1  clears cfg_err.
- in_valid  in  1  lookup request.
- in_data  in  IN_BITS  neuron input (M0 equivalent).
- out_valid  out  1  lookup result valid.
- out_data  out  OUT_BITS  neuron output (M1 equivalent).

Behaviour:
- Reset (rst_n=0 sampled at a rising edge):
  - state=IDLE, beat counter=0, shadow table=0, active table=0.
  - cfg_ready=0, cfg_done=0, cfg_err=0, out_valid=0, out_data=0.
- Table layout:
  - Entry e occupies flat bits [e*OUT_BITS +: OUT_BITS], where e is the unsigned value of in_data.
  - Beat k carries flat bits [k*WORD_W +: WORD_W].
- FSM states IDLE, LOAD, COMMIT, DRAIN.
- IDLE:
  - cfg_ready=1.
  - An accepted beat writes shadow beat 0, sets counter=1 and goes to LOAD.
  - Exception: if cfg_last=1 on that beat and NBEATS>1, it is a framing error and the FSM goes to DRAIN.
- LOAD:
  - cfg_ready=1; each accepted beat writes shadow[counter] and increments counter.
  - If counter==NBEATS-1 and cfg_last=1, go to COMMIT.
  - If cfg_last=1 early, go to DRAIN with cfg_err set.
  - If counter==NBEATS-1 and cfg_last=0, set cfg_err and go to DRAIN, which discards the remainder until a last beat.
- COMMIT (one cycle):
  - cfg_ready=0; active table <= shadow; cfg_done=1 in this cycle.
  - Return to IDLE and reset the counter.
- DRAIN:
  - cfg_ready=1; beats are accepted and discarded.
  - An accepted beat with cfg_last=1 returns the FSM to IDLE.
  - The active table is never modified on an error.
- cfg_err:
  - Set on any framing error; held until err_clr=1 or reset.
  - If a set and err_clr occur in the same cycle, set wins.
- Lookup path:
  - Latency 1: in_valid at cycle t produces out_valid=1 and out_data=active[in_data] at t+1.
  - out_valid=0 when in_valid was 0; out_data then holds its last value.
  - The lookup path is fully pipelined at 1 request/cycle and has no backpressure.
- Commit collision:
  - A lookup sampled in the same cycle as COMMIT reads the old table.
  - Lookups from the next cycle onward read the new table.
- Lookups are unaffected by LOAD and DRAIN activity.
- Reset mid-load: the partial shadow contents are discarded and the active table clears to 0.

Optional Feature:
- Macro: LUT_READBACK_EN.
- When defined, the block adds these ports:
  - rb_req  in  1.
  - rb_valid  out  1.
  - rb_ready  in  1.
  - rb_data  out  WORD_W.
  - rb_last  out  1.
- An rb_req pulse while no readback is active snapshots the active table and streams NBEATS beats in the same layout as loading, with rb_last on the final beat.
- Each beat advances only on rb_valid & rb_ready; rb_valid stays high while stalled.
- rb_req during an active readback is ignored.
- Reset values: rb_valid=0, rb_last=0, rb_data=0.
- When the macro is undefined, those ports and all readback logic are absent.

Test Plan:
- Reset, then lookup in_data=0..63 -> every out_data=0 with out_valid one cycle after each in_valid.
- Load 8 beats 0xF0,0x0F,0xAA,0x55,0xFF,0x00,0x81,0x7E with last on beat 8:
  - cfg_done pulses once.
  - in_data=4 -> 1, 0 -> 0, 9 -> 1, 17 -> 1, 40 -> 0.
- Lookup in_data=4 issued in the COMMIT cycle of a new all-zero table (prior table loaded as above) -> out_data=1; the same lookup one cycle later -> 0.
- Framing errors leave the table untouched and set cfg_err:
  - Early last on beat 3 -> cfg_err=1, cfg_done never pulses, active table unchanged.
  - 10 beats with last only on beat 10 -> cfg_err=1, block back in IDLE after beat 10.
  - err_clr -> cfg_err=0.
- With cfg_valid toggling randomly and in_valid=1 every cycle:
  - The load completes correctly.
  - Lookups return old-table values until COMMIT and new-table values from the next cycle.
- LUT_READBACK_EN: load the table above, rb_req with rb_ready stalled on beat 2 for 5 cycles -> beats 0xF0..0x7E in order, rb_data stable while stalled, rb_last on beat 8.

Source files
------------

// File: rtl/lut_table_loader.sv
// Runtime-loadable LogicNets neuron truth table: config stream fills a shadow table, commit swaps it active.
// Optional macro LUT_READBACK_EN adds a snapshot readback stream of the active table.
module lut_table_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1,
    parameter int WORD_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_last,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic                err_clr,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
`ifdef LUT_READBACK_EN
    ,
    input  logic                rb_req,
    output logic                rb_valid,
    input  logic                rb_ready,
    output logic [WORD_W-1:0]   rb_data,
    output logic                rb_last
`endif
);

    localparam int TBITS  = (1 << IN_BITS) * OUT_BITS;
    localparam int NBEATS = TBITS / WORD_W;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TBITS-1:0]    shadow_q, shadow_d;
    logic [TBITS-1:0]    active_q, active_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                accept;
    logic                err_set;

    assign cfg_ready = rst_n && (state_q != COMMIT);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_done  = (state_q == COMMIT);
    assign cfg_err   = err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // IDLE is just LOAD with the counter at zero, so both share the beat handling.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_set  = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    shadow_d[32'(cnt_q) * WORD_W +: WORD_W] = cfg_data;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d = '0;
                        if (cfg_last) begin
                            state_d = COMMIT;
                        end else begin
                            state_d = DRAIN;
                            err_set = 1'b1;
                        end
                    end else if (cfg_last) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                        err_set = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = LOAD;
                    end
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            DRAIN: begin
                if (accept && cfg_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new framing error outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = in_valid;
        out_data_d  = out_data_q;
        if (in_valid) begin
            out_data_d = active_q[32'(in_data) * OUT_BITS +: OUT_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef LUT_READBACK_EN
    logic             rb_active_q, rb_active_d;
    logic [CW-1:0]    rb_idx_q, rb_idx_d;
    logic [TBITS-1:0] rb_snap_q, rb_snap_d;

    assign rb_valid = rb_active_q;
    assign rb_data  = rb_active_q ? rb_snap_q[32'(rb_idx_q) * WORD_W +: WORD_W] : '0;
    assign rb_last  = rb_active_q && (rb_idx_q == LAST_BEAT);

    // The snapshot decouples the stream from commits that land mid-readback.
    always_comb begin
        rb_active_d = rb_active_q;
        rb_idx_d    = rb_idx_q;
        rb_snap_d   = rb_snap_q;
        if (!rb_active_q) begin
            if (rb_req) begin
                rb_active_d = 1'b1;
                rb_idx_d    = '0;
                rb_snap_d   = active_q;
            end
        end else if (rb_ready) begin
            if (rb_idx_q == LAST_BEAT) begin
                rb_active_d = 1'b0;
                rb_idx_d    = '0;
            end else begin
                rb_idx_d = rb_idx_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rb_active_q <= 1'b0;
            rb_idx_q    <= '0;
            rb_snap_q   <= '0;
        end else begin
            rb_active_q <= rb_active_d;
            rb_idx_q    <= rb_idx_d;
            rb_snap_q   <= rb_snap_d;
        end
    end
`endif

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader: reset, load/commit, commit collision, framing errors, randomized handshake.
// Readback stream is exercised when LUT_READBACK_EN is defined.
module tb_lut_table_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       cfg_last;
    logic       cfg_done;
    logic       cfg_err;
    logic       err_clr;
    logic       in_valid;
    logic [5:0] in_data;
    logic       out_valid;
    logic [0:0] out_data;
`ifdef LUT_READBACK_EN
    logic       rb_req;
    logic       rb_valid;
    logic       rb_ready;
    logic [7:0] rb_data;
    logic       rb_last;
`endif

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [63:0] tbl_a;
    logic [63:0] tbl_b;
    logic [63:0] model;

    lut_table_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .err_clr   (err_clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef LUT_READBACK_EN
        ,
        .rb_req    (rb_req),
        .rb_valid  (rb_valid),
        .rb_ready  (rb_ready),
        .rb_data   (rb_data),
        .rb_last   (rb_last)
`endif
    );

    always #5 clk = ~clk;

    // Commit pulses are counted mid-cycle so each one-cycle pulse is seen exactly once.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cfg_done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int n;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) checkOutput("cfg_ready_timeout", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic load_table(input logic [63:0] t);
        for (int k = 0; k < 8; k++) applyStimulus(t[k*8 +: 8], k == 7);
    endtask

    task automatic lookup(input int e, input logic exp, input string tag);
        in_valid = 1'b1;
        in_data  = 6'(e);
        step();
        in_valid = 1'b0;
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput(tag, {31'd0, out_data}, {31'd0, exp});
    endtask

    initial begin
        int b;
        int cyc;
        int extra;
        int e;
        logic pend;
        logic acc;
        logic expv;

        tbl_a = {8'h7E, 8'h81, 8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};
        tbl_b = ~tbl_a;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
        err_clr = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef LUT_READBACK_EN
        rb_req = 1'b0; rb_ready = 1'b1;
`endif
        step();
        step();
        checkOutput("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        checkOutput("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        checkOutput("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {31'd0, out_data}, 32'd0);
`ifdef LUT_READBACK_EN
        checkOutput("rst_rb_valid", {31'd0, rb_valid}, 32'd0);
        checkOutput("rst_rb_last", {31'd0, rb_last}, 32'd0);
        checkOutput("rst_rb_data", {24'd0, rb_data}, 32'd0);
`endif
        rst_n = 1'b1;
        step();
        checkOutput("idle_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        for (int i = 0; i < 64; i++) lookup(i, 1'b0, "zero_table");
        step();
        checkOutput("idle_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("idle_out_hold", {31'd0, out_data}, 32'd0);

        done_cnt = 0;
        load_table(tbl_a);
        step();
        checkOutput("load_a_done_cnt", done_cnt, 32'd1);
        lookup(4, 1'b1, "a_e4");
        lookup(0, 1'b0, "a_e0");
        lookup(9, 1'b1, "a_e9");
        lookup(17, 1'b1, "a_e17");
        lookup(40, 1'b0, "a_e40");
        lookup(48, 1'b1, "a_e48");
        lookup(63, 1'b0, "a_e63");

        for (int k = 0; k < 7; k++) applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("commit_done_high", {31'd0, cfg_done}, 32'd1);
        checkOutput("commit_not_ready", {31'd0, cfg_ready}, 32'd0);
        lookup(4, 1'b1, "collide_old");
        lookup(4, 1'b0, "collide_new");

        load_table(tbl_a);
        step();
        done_cnt = 0;
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b1);
        step();
        checkOutput("early_last_err", {31'd0, cfg_err}, 32'd1);
        checkOutput("early_last_no_done", done_cnt, 32'd0);
        lookup(4, 1'b1, "early_keep_e4");
        lookup(9, 1'b1, "early_keep_e9");
        lookup(40, 1'b0, "early_keep_e40");
        applyStimulus(8'h00, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checkOutput("err_clr", {31'd0, cfg_err}, 32'd0);

        for (int k = 0; k < 7; k++) applyStimulus(8'h33, 1'b0);
        err_clr = 1'b1;
        applyStimulus(8'h33, 1'b0);
        err_clr = 1'b0;
        checkOutput("overlong_set_wins", {31'd0, cfg_err}, 32'd1);
        applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h55, 1'b1);
        step();
        checkOutput("overlong_no_done", done_cnt, 32'd0);
        lookup(4, 1'b1, "overlong_keep_e4");
        load_table(tbl_b);
        step();
        checkOutput("after_drain_done", done_cnt, 32'd1);
        checkOutput("err_sticky", {31'd0, cfg_err}, 32'd1);
        lookup(4, 1'b0, "b_e4");
        lookup(0, 1'b1, "b_e0");
        lookup(40, 1'b1, "b_e40");
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checkOutput("err_clr2", {31'd0, cfg_err}, 32'd0);

        done_cnt = 0;
        model = tbl_b;
        b = 0; cyc = 0; extra = 0; pend = 1'b0;
        in_valid = 1'b1;
        while (cyc < 300 && extra < 3) begin
            cfg_valid = (b < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_data  = (b < 8) ? tbl_a[b*8 +: 8] : 8'h00;
            cfg_last  = (b == 7);
            e = int'($urandom_range(0, 63));
            in_data = 6'(e);
            expv = model[e];
            acc = cfg_valid;
            step();
            checkOutput("rand_lookup", {31'd0, out_data}, {31'd0, expv});
            if (pend) begin
                model = tbl_a;
                pend = 1'b0;
            end
            if (acc) begin
                if (b == 7) pend = 1'b1;
                b++;
            end
            if (b == 8 && !pend) extra++;
            cyc++;
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        in_valid  = 1'b0;
        step();
        checkOutput("rand_complete", b, 32'd8);
        checkOutput("rand_done_cnt", done_cnt, 32'd1);
        lookup(17, 1'b1, "rand_final_e17");

`ifdef LUT_READBACK_EN
        rb_ready = 1'b1;
        rb_req = 1'b1;
        step();
        rb_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin
                rb_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    checkOutput("rb_stall_valid", {31'd0, rb_valid}, 32'd1);
                    checkOutput("rb_stall_data", {24'd0, rb_data}, {24'd0, tbl_a[15:8]});
                end
                rb_ready = 1'b1;
            end
            if (k == 3) rb_req = 1'b1;
            checkOutput("rb_valid", {31'd0, rb_valid}, 32'd1);
            checkOutput("rb_data", {24'd0, rb_data}, {24'd0, tbl_a[k*8 +: 8]});
            checkOutput("rb_last", {31'd0, rb_last}, {31'd0, k == 7});
            step();
            rb_req = 1'b0;
        end
        checkOutput("rb_end_valid", {31'd0, rb_valid}, 32'd0);
`endif

        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checkOutput("midload_rst_err", {31'd0, cfg_err}, 32'd0);
        lookup(4, 1'b0, "midload_rst_e4");
        lookup(17, 1'b0, "midload_rst_e17");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
